// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment display scanner.
// Each digit owns a slot of SLOT cycles. The first BLANK_CYCLES cycles of a slot are dark
// to suppress ghosting. New display data is double-buffered and only swapped in at frame
// boundaries, so a frame is never shown half-old and half-new.
module seg_scan_ctrl #(
    parameter int DIGITS         = 4,
    parameter int CLK_HZ         = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLANK_CYCLES   = 50,
    parameter int COM_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  sysClk,
    input  logic                  sysRst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   dataIn,
    input  logic [DIGITS-1:0]     dpIn,
    input  logic [DIGITS-1:0]     blankMask,
    output logic [DIGITS-1:0]     COM,
    output logic [7:0]            SEG,
    output logic                  frameDone
);

    localparam int SLOT = CLK_HZ / SCAN_HZ;
    localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     CNT_LAST  = CW'(SLOT - 1);
    localparam logic [CW-1:0]     BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] COM_OFF   = (COM_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]        SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

    // Reject configurations that cannot produce a visible drive window.
    generate
        if (BLANK_CYCLES >= SLOT) begin : g_bad_blank
            $error("seg_scan_ctrl: BLANK_CYCLES must be smaller than CLK_HZ/SCAN_HZ");
        end
        if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
            $error("seg_scan_ctrl: DIGITS must be in 2..8");
        end
    endgenerate

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                frame_end;
    logic                fd_q, fd_d;

    logic [4*DIGITS-1:0] act_data_q, act_data_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic                pend_q, pend_d;

    logic [DIGITS-1:0]   com_q, com_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   com_log;
    logic [7:0]          seg_log;
    logic [3:0]          nibble;

    // Hex digit to logical (active-high) segments g..a.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign frame_end = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    // Slot/digit counters and the BLANK/DRIVE phase that the next counter value falls into.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        state_d = (cnt_d < BLANK_END) ? ST_BLANK : ST_DRIVE;
        fd_d    = frame_end;
    end

    // Shadow/active double buffer; a load coinciding with the frame boundary bypasses the shadow.
    always_comb begin
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        sh_data_d   = sh_data_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        pend_d      = pend_q;
        if (load) begin
            sh_data_d  = dataIn;
            sh_dp_d    = dpIn;
            sh_blank_d = blankMask;
            if (frame_end) begin
                act_data_d  = dataIn;
                act_dp_d    = dpIn;
                act_blank_d = blankMask;
                pend_d      = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end else if (frame_end && pend_q) begin
            act_data_d  = sh_data_q;
            act_dp_d    = sh_dp_q;
            act_blank_d = sh_blank_q;
            pend_d      = 1'b0;
        end
    end

    // Logical COM/SEG for the current slot, then polarity adjustment before registering.
    always_comb begin
        com_log = '0;
        seg_log = '0;
        nibble  = act_data_q[{idx_q, 2'b00} +: 4];
        if (state_q == ST_DRIVE) begin
            com_log[idx_q] = 1'b1;
            if (!act_blank_q[idx_q]) begin
                seg_log = {act_dp_q[idx_q], hex7(nibble)};
            end
        end
        com_d = (COM_ACTIVE_LOW != 0) ? ~com_log : com_log;
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_log : seg_log;
    end

    // State, counters, buffers and registered outputs.
    always_ff @(posedge sysClk or negedge sysRst) begin
        if (!sysRst) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            fd_q        <= 1'b0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '0;
            pend_q      <= 1'b0;
            com_q       <= COM_OFF;
            seg_q       <= SEG_OFF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            fd_q        <= fd_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            sh_data_q   <= sh_data_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            pend_q      <= pend_d;
            com_q       <= com_d;
            seg_q       <= seg_d;
        end
    end

    assign COM       = com_q;
    assign SEG       = seg_q;
    assign frameDone = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed stimulus against a frame-level reference model.
module tb_seg_scan_ctrl;

    localparam int DIGITS  = 4;
    localparam int CLK_HZ  = 1000;
    localparam int SCAN_HZ = 100;
    localparam int BLANK   = 2;
    localparam int SLOT    = CLK_HZ / SCAN_HZ;
    localparam int FRAME   = SLOT * DIGITS;

    logic        sysClk = 1'b0;
    logic        sysRst;
    logic        load;
    logic [15:0] dataIn;
    logic [3:0]  dpIn;
    logic [3:0]  blankMask;
    logic [3:0]  COM;
    logic [7:0]  SEG;
    logic        frameDone;

    int n_tests = 0;
    int n_fail  = 0;

    seg_scan_ctrl #(
        .DIGITS         (DIGITS),
        .CLK_HZ         (CLK_HZ),
        .SCAN_HZ        (SCAN_HZ),
        .BLANK_CYCLES   (BLANK),
        .COM_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .sysClk    (sysClk),
        .sysRst    (sysRst),
        .load      (load),
        .dataIn    (dataIn),
        .dpIn      (dpIn),
        .blankMask (blankMask),
        .COM       (COM),
        .SEG       (SEG),
        .frameDone (frameDone)
    );

    always #5 sysClk = ~sysClk;

    // Logical segment patterns g..a for hex digits 0..F.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: cycles since reset release plus the displayed and queued content.
    int          m_n;
    logic [15:0] m_act_d, m_sh_d;
    logic [3:0]  m_act_dp, m_sh_dp, m_act_bl, m_sh_bl;
    bit          m_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_act_d = '0; m_sh_d = '0;
        m_act_dp = '0; m_sh_dp = '0;
        m_act_bl = '0; m_sh_bl = '0;
        m_pend = 1'b0;
    endtask

    // One clock: predict the outputs that the coming edge registers, advance the model, compare.
    task automatic step();
        int pos, c, d;
        logic [3:0] nib;
        logic [3:0] e_com;
        logic [7:0] e_seg;
        logic       e_fd;
        pos = m_n % FRAME;
        c   = pos % SLOT;
        d   = pos / SLOT;
        if (c < BLANK) begin
            e_com = 4'hF;
            e_seg = 8'hFF;
        end else begin
            e_com = ~(4'b0001 << d);
            nib   = m_act_d[d*4 +: 4];
            e_seg = m_act_bl[d] ? 8'hFF : ~{m_act_dp[d], seg_tab[nib]};
        end
        e_fd = (pos == FRAME - 1);
        @(posedge sysClk);
        if (load) begin
            m_sh_d = dataIn; m_sh_dp = dpIn; m_sh_bl = blankMask;
            if (pos == FRAME - 1) begin
                m_act_d = dataIn; m_act_dp = dpIn; m_act_bl = blankMask;
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
            end
        end else if (pos == FRAME - 1 && m_pend) begin
            m_act_d = m_sh_d; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl;
            m_pend = 1'b0;
        end
        m_n++;
        #1;
        check("COM", 32'(COM), 32'(e_com));
        check("SEG", 32'(SEG), 32'(e_seg));
        check("frameDone", 32'(frameDone), 32'(e_fd));
        load = 1'b0;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic run_until_pos(input int p);
        for (int i = 0; i < FRAME && (m_n % FRAME) != p; i++) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        dataIn = d; dpIn = dp; blankMask = bl; load = 1'b1;
        step();
    endtask

    initial begin
        sysRst = 1'b0; load = 1'b0; dataIn = '0; dpIn = '0; blankMask = '0;
        model_reset();
        #12;
        check("rst_COM", 32'(COM), 32'h0000_000F);
        check("rst_SEG", 32'(SEG), 32'h0000_00FF);
        check("rst_frameDone", 32'(frameDone), 32'h0);
        @(negedge sysClk);
        sysRst = 1'b1;

        // Idle scanning of the all-zero buffer.
        run(2 * FRAME);

        // Mid-frame load only becomes visible at the next frame.
        run_until_pos(15);
        do_load(16'h9A3F, 4'b0010, 4'b0000);
        run(2 * FRAME);

        // Two loads in one frame: the last one wins.
        run_until_pos(5);
        do_load(16'h1111, 4'b0000, 4'b0000);
        run(3);
        do_load(16'h2222, 4'b0000, 4'b0000);
        run(2 * FRAME);

        // Load exactly in the frame-boundary cycle.
        run_until_pos(FRAME - 1);
        do_load(16'h7777, 4'b0000, 4'b0000);
        run(2 * FRAME);

        // Blank mask keeps COM active but darkens the segments.
        run_until_pos(20);
        do_load(16'h1234, 4'b1000, 4'b0101);
        run(2 * FRAME);

        // Reset in the middle of digit 2's slot (cnt=5, idx=2).
        run_until_pos(25);
        #2;
        sysRst = 1'b0;
        #1;
        check("midrst_COM", 32'(COM), 32'h0000_000F);
        check("midrst_SEG", 32'(SEG), 32'h0000_00FF);
        check("midrst_frameDone", 32'(frameDone), 32'h0);
        @(posedge sysClk);
        #1;
        check("midrst_hold_COM", 32'(COM), 32'h0000_000F);
        check("midrst_hold_SEG", 32'(SEG), 32'h0000_00FF);
        @(negedge sysClk);
        sysRst = 1'b1;
        model_reset();
        run(FRAME + 10);

        // Random loads, with extra weight on the boundary cycle.
        for (int i = 0; i < 2000; i++) begin
            if (($urandom % 25) == 0 ||
                ((m_n % FRAME) == FRAME - 1 && ($urandom % 3) == 0)) begin
                do_load(16'($urandom), 4'($urandom), 4'($urandom));
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
